semaforo_ctrl: RTL and testbench

SEMAFORO_CTRL -- requirements
Module: semaforo_ctrl

---
 rtl/semaforo_ctrl_if.sv | 23 ++
 rtl/semaforo_ctrl.sv | 139 +++++++++++++
 tb/tb_semaforo_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/semaforo_ctrl_if.sv
// rtl/semaforo_ctrl_if.sv - timer, request and lamp signals of the traffic light controller
interface semaforo_ctrl_if;
  logic       tempo_zero;
  logic       tempo_15;
  logic       botao;
  logic       casoEsp;
  logic       carregar;
  logic [1:0] dez_preset;
  logic [3:0] unid_preset;
  logic [2:0] luz_a;
  logic [2:0] luz_b;
  logic       pedestre;

  modport master (
    input  tempo_zero, tempo_15, botao, casoEsp,
    output carregar, dez_preset, unid_preset, luz_a, luz_b, pedestre
  );

  modport slave (
    output tempo_zero, tempo_15, botao, casoEsp,
    input  carregar, dez_preset, unid_preset, luz_a, luz_b, pedestre
  );
endinterface

// File: rtl/semaforo_ctrl.sv
// rtl/semaforo_ctrl.sv - two-road traffic light FSM with pedestrian shortening and night blink
module semaforo_ctrl (
  input  logic              clock,
  input  logic              reset_n,
  semaforo_ctrl_if.master   bus
);
  typedef enum logic [2:0] {
    VERDE_A   = 3'd0,
    AMARELO_A = 3'd1,
    VERDE_B   = 3'd2,
    AMARELO_B = 3'd3,
    NOITE     = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       carregar_q, carregar_d;
  logic [1:0] dez_q, dez_d;
  logic [3:0] unid_q, unid_d;
  logic [2:0] luz_a_q, luz_a_d;
  logic [2:0] luz_b_q, luz_b_d;
  logic       pedestre_q, pedestre_d;
  logic       pedido_q, pedido_d;
  logic       passou15_q, passou15_d;
  logic       pisca_q, pisca_d;
  logic       ign_q, ign_d;
  logic       tz, t15, enter;

  // Timer flags are stale during a load cycle and the cycle after it.
  assign tz  = bus.tempo_zero & ~carregar_q & ~ign_q;
  assign t15 = bus.tempo_15   & ~carregar_q & ~ign_q;

  always_comb begin
    state_d    = state_q;
    carregar_d = 1'b0;
    dez_d      = dez_q;
    unid_d     = unid_q;
    pedido_d   = pedido_q;
    passou15_d = passou15_q;
    pisca_d    = pisca_q;
    ign_d      = carregar_q;
    enter      = 1'b0;
    luz_a_d    = 3'b001;
    luz_b_d    = 3'b100;
    pedestre_d = 1'b0;

    if (state_q != NOITE && bus.botao) pedido_d = 1'b1;
    if (t15) passou15_d = 1'b1;

    case (state_q)
      VERDE_A, AMARELO_A, VERDE_B, AMARELO_B: begin
        if (bus.casoEsp) begin
          state_d = NOITE;
          enter   = 1'b1;
        end else if (tz) begin
          enter = 1'b1;
          case (state_q)
            VERDE_A:   state_d = AMARELO_A;
            AMARELO_A: state_d = VERDE_B;
            VERDE_B:   state_d = AMARELO_B;
            default:   state_d = VERDE_A;
          endcase
        end else if (state_q == VERDE_A && (pedido_q || bus.botao) && !passou15_q
                     && !t15 && !carregar_q) begin
          carregar_d = 1'b1;
          dez_d      = 2'd1;
          unid_d     = 4'd5;
          passou15_d = 1'b1;
        end
      end
      NOITE: begin
        if (!bus.casoEsp) begin
          state_d = AMARELO_A;
          enter   = 1'b1;
        end else begin
          pisca_d = ~pisca_q;
        end
      end
      default: begin
        state_d = VERDE_A;
        enter   = 1'b1;
      end
    endcase

    if (enter) begin
      carregar_d = 1'b1;
      pisca_d    = (state_d == NOITE);
      if (state_d == VERDE_A) passou15_d = 1'b0;
      if (state_d == VERDE_B || state_d == NOITE) pedido_d = 1'b0;
      case (state_d)
        VERDE_A, VERDE_B:     begin dez_d = 2'd3; unid_d = 4'd0; end
        AMARELO_A, AMARELO_B: begin dez_d = 2'd0; unid_d = 4'd5; end
        default:              begin dez_d = 2'd0; unid_d = 4'd0; end
      endcase
    end

    case (state_d)
      AMARELO_A: begin luz_a_d = 3'b010; luz_b_d = 3'b100; end
      VERDE_B:   begin luz_a_d = 3'b100; luz_b_d = 3'b001; pedestre_d = 1'b1; end
      AMARELO_B: begin luz_a_d = 3'b100; luz_b_d = 3'b010; end
      NOITE:     begin luz_a_d = {1'b0, pisca_d, 1'b0}; luz_b_d = {1'b0, pisca_d, 1'b0}; end
      default:   begin luz_a_d = 3'b001; luz_b_d = 3'b100; end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= VERDE_A;
      carregar_q <= 1'b1;
      dez_q      <= 2'd3;
      unid_q     <= 4'd0;
      luz_a_q    <= 3'b001;
      luz_b_q    <= 3'b100;
      pedestre_q <= 1'b0;
      pedido_q   <= 1'b0;
      passou15_q <= 1'b0;
      pisca_q    <= 1'b0;
      ign_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      carregar_q <= carregar_d;
      dez_q      <= dez_d;
      unid_q     <= unid_d;
      luz_a_q    <= luz_a_d;
      luz_b_q    <= luz_b_d;
      pedestre_q <= pedestre_d;
      pedido_q   <= pedido_d;
      passou15_q <= passou15_d;
      pisca_q    <= pisca_d;
      ign_q      <= ign_d;
    end
  end

  assign bus.carregar    = carregar_q;
  assign bus.dez_preset  = dez_q;
  assign bus.unid_preset = unid_q;
  assign bus.luz_a       = luz_a_q;
  assign bus.luz_b       = luz_b_q;
  assign bus.pedestre    = pedestre_q;
endmodule

// File: tb/tb_semaforo_ctrl.sv
// tb/tb_semaforo_ctrl.sv - scoreboard bench for semaforo_ctrl output events
module tb_semaforo_ctrl;
  logic clock;
  logic reset_n;
  semaforo_ctrl_if bus ();

  semaforo_ctrl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int ev_idx = 0;
  logic [13:0] exp_q[$];
  logic [13:0] prev_vec = '1;
  logic [13:0] cur_vec;
  logic [13:0] exp_vec;

  function automatic logic [13:0] ev(input logic c, input logic [1:0] d, input logic [3:0] u,
                                     input logic [2:0] la, input logic [2:0] lb, input logic p);
    return {c, d, u, la, lb, p};
  endfunction

  // Every change of the registered output vector must match the next queued expectation.
  always @(negedge clock) begin
    cur_vec = {bus.carregar, bus.dez_preset, bus.unid_preset, bus.luz_a, bus.luz_b, bus.pedestre};
    if (cur_vec !== prev_vec) begin
      prev_vec = cur_vec;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event act=%b", cur_vec);
      end else begin
        exp_vec = exp_q.pop_front();
        if (cur_vec !== exp_vec) begin
          failures++;
          $display("FAIL event%0d act=%b exp=%b", ev_idx, cur_vec, exp_vec);
        end
      end
      ev_idx++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [13:0] e);
    exp_q.push_back(e);
  endtask

  task automatic phase_step(input logic [13:0] load_ev, input logic [13:0] drop_ev);
    repeat (3) tick();
    bus.tempo_zero = 1'b1;
    push(load_ev);
    push(drop_ev);
    tick();
    bus.tempo_zero = 1'b0;
    tick();
  endtask

  logic [13:0] va_l, va_d, aa_l, aa_d, vb_l, vb_d, ab_l, ab_d, sh_l, sh_d;

  initial begin
    va_l = ev(1'b1, 2'd3, 4'd0, 3'b001, 3'b100, 1'b0);
    va_d = ev(1'b0, 2'd3, 4'd0, 3'b001, 3'b100, 1'b0);
    aa_l = ev(1'b1, 2'd0, 4'd5, 3'b010, 3'b100, 1'b0);
    aa_d = ev(1'b0, 2'd0, 4'd5, 3'b010, 3'b100, 1'b0);
    vb_l = ev(1'b1, 2'd3, 4'd0, 3'b100, 3'b001, 1'b1);
    vb_d = ev(1'b0, 2'd3, 4'd0, 3'b100, 3'b001, 1'b1);
    ab_l = ev(1'b1, 2'd0, 4'd5, 3'b100, 3'b010, 1'b0);
    ab_d = ev(1'b0, 2'd0, 4'd5, 3'b100, 3'b010, 1'b0);
    sh_l = ev(1'b1, 2'd1, 4'd5, 3'b001, 3'b100, 1'b0);
    sh_d = ev(1'b0, 2'd1, 4'd5, 3'b001, 3'b100, 1'b0);

    reset_n = 1'b0;
    bus.tempo_zero = 1'b0;
    bus.tempo_15   = 1'b0;
    bus.botao      = 1'b0;
    bus.casoEsp    = 1'b0;
    push(va_l);
    repeat (2) tick();
    reset_n = 1'b1;
    push(va_d);

    // Full normal cycle
    phase_step(aa_l, aa_d);
    phase_step(vb_l, vb_d);
    phase_step(ab_l, ab_d);
    phase_step(va_l, va_d);

    // Pedestrian shortening, then a second request that must not reload
    repeat (2) tick();
    bus.botao = 1'b1;
    push(sh_l);
    push(sh_d);
    tick();
    bus.botao = 1'b0;
    repeat (3) tick();
    bus.botao = 1'b1;
    tick();
    bus.botao = 1'b0;
    phase_step(aa_l, aa_d);
    phase_step(vb_l, vb_d);
    phase_step(ab_l, ab_d);
    phase_step(va_l, va_d);

    // tempo_15 already seen: request is held without reload
    repeat (2) tick();
    bus.tempo_15 = 1'b1;
    tick();
    bus.tempo_15 = 1'b0;
    repeat (2) tick();
    bus.botao = 1'b1;
    tick();
    bus.botao = 1'b0;
    repeat (3) tick();

    // tempo_zero and request together: advance wins
    bus.tempo_zero = 1'b1;
    bus.botao      = 1'b1;
    push(aa_l);
    push(aa_d);
    tick();
    bus.tempo_zero = 1'b0;
    bus.botao      = 1'b0;
    tick();
    phase_step(vb_l, vb_d);

    // Night mode from VERDE_B, blink, then exit to AMARELO_A
    repeat (3) tick();
    bus.casoEsp = 1'b1;
    push(ev(1'b1, 2'd0, 4'd0, 3'b010, 3'b010, 1'b0));
    push(ev(1'b0, 2'd0, 4'd0, 3'b000, 3'b000, 1'b0));
    push(ev(1'b0, 2'd0, 4'd0, 3'b010, 3'b010, 1'b0));
    push(ev(1'b0, 2'd0, 4'd0, 3'b000, 3'b000, 1'b0));
    push(ev(1'b0, 2'd0, 4'd0, 3'b010, 3'b010, 1'b0));
    tick();
    bus.tempo_zero = 1'b1;
    repeat (4) tick();
    bus.tempo_zero = 1'b0;
    bus.casoEsp = 1'b0;
    push(aa_l);
    push(aa_d);
    tick();

    // tempo_zero during the load cycle and the one after is ignored
    bus.tempo_zero = 1'b1;
    repeat (2) tick();
    bus.tempo_zero = 1'b0;
    phase_step(vb_l, vb_d);
    phase_step(ab_l, ab_d);

    // Asynchronous reset mid-AMARELO_B, away from any clock edge
    tick();
    #2;
    reset_n = 1'b0;
    push(va_l);
    repeat (2) tick();
    reset_n = 1'b1;
    bus.tempo_zero = 1'b1;
    push(va_d);
    repeat (2) tick();
    bus.tempo_zero = 1'b0;
    phase_step(aa_l, aa_d);

    repeat (3) tick();
    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events act=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
